grf_mp: RTL and testbench

Parametrised multi-port general register file with write-to-read forwarding and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the pipelined core's decode stage. It supports multi-issue write-back, configurable read-port count and register width. Decode uses the scoreboard to stall on outstanding producers instead of recomputing hazards from pipeline-stage addresses.

---
 rtl/grf_pkg.sv | 34 +++
 rtl/grf_scoreboard.sv | 69 ++++++
 rtl/grf_mp.sv | 88 ++++++++
 tb/tb_grf_mp.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants for the multi-port register file and its write-back arbiter,
// plus the per-address write-match counter used by the scoreboard.
package grf_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;
    localparam int PW_DEF   = 2;

    // Upper bounds of the generic match function; callers zero-extend into these.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 8;

    function automatic int unsigned count_writes(
        input logic [MAX_WR-1:0]        we,
        input logic [MAX_WR*MAX_AW-1:0] wa,
        input int unsigned              aw,
        input int unsigned              addr
    );
        int unsigned n;
        logic        match;
        n = 0;
        for (int k = 0; k < MAX_WR; k++) begin
            match = we[k];
            for (int b = 0; b < MAX_AW; b++) begin
                if (b < int'(aw) && wa[k*aw + b] != addr[b]) match = 1'b0;
            end
            if (match) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-writer scoreboard: one saturating counter per register, issue
// admission against the post-write count, and busy lookups for the read ports.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    rbusy,
    output logic              iss_rdy
);

    typedef logic [PW-1:0] cnt_t;
    localparam int unsigned CMAX = (1 << PW) - 1;

    cnt_t                    cnt       [NREG];
    cnt_t                    cnt_d     [NREG];
    int unsigned             dec       [NREG];
    int unsigned             post      [NREG];
    logic                    issue_hit [NREG];
    logic [MAX_WR-1:0]        we_x;
    logic [MAX_WR*MAX_AW-1:0] wa_x;

    assign we_x = MAX_WR'(we);
    assign wa_x = (MAX_WR*MAX_AW)'(wa);

    // post = count left after this cycle's retirements, clamped at zero
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r]  = count_writes(we_x, wa_x, AW, r);
            post[r] = (32'(cnt[r]) > dec[r]) ? 32'(cnt[r]) - dec[r] : 32'd0;
        end
    end

    assign iss_rdy = (iss_a == '0) || (post[iss_a] < CMAX);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            issue_hit[r] = iss_v && iss_rdy && (iss_a == AW'(r)) && (r != 0);
            cnt_d[r] = (32'(cnt[r]) + 32'(issue_hit[r]) > dec[r])
                     ? cnt_t'(32'(cnt[r]) + 32'(issue_hit[r]) - dec[r])
                     : '0;
        end
    end

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rbusy[j] = post[ra[j*AW +: AW]] != 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset) cnt[r] <= '0;
            else       cnt[r] <= cnt_d[r];
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-port register file with same-cycle write forwarding; the highest write
// port wins on address collisions, register 0 reads as zero.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF,
    parameter int PW   = PW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic [NWR*DW-1:0] wd,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    output logic              iss_rdy
);

    logic [DW-1:0]  mem     [NREG];
    logic           wr_en   [NREG];
    logic [DW-1:0]  wr_data [NREG];
    logic [AW-1:0]  rsel    [NRD];
    logic [DW-1:0]  rval    [NRD];
    logic [NWR-1:0] we_g;

    // Writes presented while in reset neither land nor forward.
    assign we_g = reset ? '0 : we;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_en[r]   = 1'b0;
            wr_data[r] = '0;
            for (int k = 0; k < NWR; k++) begin
                if (we_g[k] && wa[k*AW +: AW] == AW'(r) && r != 0) begin
                    wr_en[r]   = 1'b1;
                    wr_data[r] = wd[k*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset)         mem[r] <= '0;
            else if (wr_en[r]) mem[r] <= wr_data[r];
        end
    end

    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rsel[j] = ra[j*AW +: AW];
            rval[j] = '0;
            if (rsel[j] != '0 && int'(rsel[j]) < NREG) begin
                rval[j] = mem[rsel[j]];
                for (int k = 0; k < NWR; k++) begin
                    if (we_g[k] && wa[k*AW +: AW] == rsel[j]) rval[j] = wd[k*DW +: DW];
                end
            end
            rd[j*DW +: DW] = rval[j];
        end
    end

    grf_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .NWR  (NWR),
        .PW   (PW)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .we      (we_g),
        .wa      (wa),
        .iss_v   (iss_v),
        .iss_a   (iss_a),
        .ra      (ra),
        .rbusy   (rbusy),
        .iss_rdy (iss_rdy)
    );

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: directed scenarios plus randomized traffic
// compared against a behavioural register-file/scoreboard model.
module tb_grf_mp;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int PW   = 2;
    localparam int CMAX = (1 << PW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NWR-1:0]    we;
    logic [NWR*AW-1:0] wa;
    logic [NWR*DW-1:0] wd;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rbusy;
    logic              iss_v;
    logic [AW-1:0]     iss_a;
    logic              iss_rdy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [NREG];
    int            m_cnt [NREG];
    logic [DW-1:0] exp_rd   [NRD];
    logic          exp_busy [NRD];
    logic          exp_rdy;

    always #5 clk = ~clk;

    grf_mp #(
        .DW (DW), .NREG (NREG), .AW (AW), .NRD (NRD), .NWR (NWR), .PW (PW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra),
        .rd      (rd),
        .rbusy   (rbusy),
        .iss_v   (iss_v),
        .iss_a   (iss_a),
        .iss_rdy (iss_rdy)
    );

    function automatic int n_writes(int a);
        int n = 0;
        for (int k = 0; k < NWR; k++)
            if (we[k] && int'(wa[k*AW +: AW]) == a) n++;
        return n;
    endfunction

    function automatic int pending(int a);
        int p;
        p = m_cnt[a] - n_writes(a);
        return (p < 0) ? 0 : p;
    endfunction

    function automatic void model_eval();
        int a;
        for (int j = 0; j < NRD; j++) begin
            a = int'(ra[j*AW +: AW]);
            exp_rd[j] = '0;
            if (a != 0) begin
                exp_rd[j] = m_mem[a];
                for (int k = 0; k < NWR; k++)
                    if (we[k] && int'(wa[k*AW +: AW]) == a) exp_rd[j] = wd[k*DW +: DW];
            end
            exp_busy[j] = pending(a) != 0;
        end
        exp_rdy = (iss_a == '0) || (pending(int'(iss_a)) < CMAX);
    endfunction

    task automatic model_commit();
        int c;
        logic acc;
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                m_mem[r] = '0;
                m_cnt[r] = 0;
            end
        end else begin
            model_eval();
            acc = iss_v && exp_rdy && iss_a != '0;
            for (int r = 1; r < NREG; r++) begin
                c = m_cnt[r] + ((acc && int'(iss_a) == r) ? 1 : 0) - n_writes(r);
                m_cnt[r] = (c < 0) ? 0 : c;
                for (int k = 0; k < NWR; k++)
                    if (we[k] && int'(wa[k*AW +: AW]) == r) m_mem[r] = wd[k*DW +: DW];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        we    = '0;
        wa    = '0;
        wd    = '0;
        iss_v = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ra    = '0;
        iss_a = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            ra    = {AW'(a), AW'(a)};
            iss_a = AW'(a);
            #1;
            total++;
            if (rd[0 +: DW] !== '0) begin
                bad++; $display("FAIL reset_rd0 a=%0d got=%h want=0", a, rd[0 +: DW]);
            end
            total++;
            if (rd[DW +: DW] !== '0) begin
                bad++; $display("FAIL reset_rd1 a=%0d got=%h want=0", a, rd[DW +: DW]);
            end
            total++;
            if (rbusy !== 2'b00) begin
                bad++; $display("FAIL reset_rbusy a=%0d got=%b want=00", a, rbusy);
            end
            total++;
            if (iss_rdy !== 1'b1) begin
                bad++; $display("FAIL reset_iss_rdy a=%0d got=%b want=1", a, iss_rdy);
            end
        end
        tick();
    endtask

    task automatic test_write_priority();
        idle();
        we = 2'b11;
        wa = {AW'(5), AW'(5)};
        wd = {32'h0000_2222, 32'h0000_1111};
        ra = {AW'(0), AW'(5)};
        #1;
        total++;
        if (rd[0 +: DW] !== 32'h2222) begin
            bad++; $display("FAIL prio_fwd got=%h want=00002222", rd[0 +: DW]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd[0 +: DW] !== 32'h2222) begin
            bad++; $display("FAIL prio_stored got=%h want=00002222", rd[0 +: DW]);
        end
        we = 2'b01;
        wa = {AW'(0), AW'(0)};
        wd = {32'h0, 32'hDEAD};
        ra = {AW'(0), AW'(0)};
        #1;
        total++;
        if (rd[0 +: DW] !== '0) begin
            bad++; $display("FAIL r0_fwd got=%h want=0", rd[0 +: DW]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd[DW +: DW] !== '0) begin
            bad++; $display("FAIL r0_stored got=%h want=0", rd[DW +: DW]);
        end
        tick();
    endtask

    task automatic test_issue_limit();
        idle();
        ra = {AW'(0), AW'(7)};
        for (int i = 0; i < 3; i++) begin
            iss_v = 1'b1;
            iss_a = AW'(7);
            #1;
            total++;
            if (iss_rdy !== 1'b1) begin
                bad++; $display("FAIL limit_accept i=%0d got=%b want=1", i, iss_rdy);
            end
            tick();
        end
        #1;
        total++;
        if (iss_rdy !== 1'b0) begin
            bad++; $display("FAIL limit_full got=%b want=0", iss_rdy);
        end
        total++;
        if (rbusy[0] !== 1'b1) begin
            bad++; $display("FAIL limit_busy got=%b want=1", rbusy[0]);
        end
        tick();
        we = 2'b01;
        wa = {AW'(0), AW'(7)};
        #1;
        total++;
        if (iss_rdy !== 1'b1) begin
            bad++; $display("FAIL limit_retire_frees got=%b want=1", iss_rdy);
        end
        tick();
        idle();
        iss_v = 1'b1;
        #1;
        total++;
        if (iss_rdy !== 1'b0) begin
            bad++; $display("FAIL limit_net_hold got=%b want=0", iss_rdy);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            we = 2'b01;
            wa = {AW'(0), AW'(7)};
            #1;
            total++;
            if (rbusy[0] !== (i < 2)) begin
                bad++; $display("FAIL limit_drain i=%0d got=%b want=%b", i, rbusy[0], i < 2);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_issue_then_write();
        idle();
        iss_v = 1'b1;
        iss_a = AW'(9);
        ra    = {AW'(0), AW'(9)};
        #1;
        total++;
        if (rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL r9_same_cycle got=%b want=0", rbusy[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rbusy[0] !== 1'b1) begin
            bad++; $display("FAIL r9_busy got=%b want=1", rbusy[0]);
        end
        tick();
        we = 2'b01;
        wa = {AW'(0), AW'(9)};
        wd = {32'h0, 32'hABCD};
        #1;
        total++;
        if (rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL r9_retire_busy got=%b want=0", rbusy[0]);
        end
        total++;
        if (rd[0 +: DW] !== 32'hABCD) begin
            bad++; $display("FAIL r9_fwd got=%h want=0000abcd", rd[0 +: DW]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd[0 +: DW] !== 32'hABCD) begin
            bad++; $display("FAIL r9_stored got=%h want=0000abcd", rd[0 +: DW]);
        end
    endtask

    task automatic test_clamp();
        idle();
        we = 2'b01;
        wa = {AW'(0), AW'(3)};
        wd = {32'h0, 32'h33};
        ra = {AW'(4), AW'(3)};
        tick();
        idle();
        #1;
        total++;
        if (rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL clamp_r3 got=%b want=0", rbusy[0]);
        end
        iss_v = 1'b1;
        iss_a = AW'(4);
        tick();
        idle();
        #1;
        total++;
        if (rbusy[1] !== 1'b1) begin
            bad++; $display("FAIL clamp_r4_busy got=%b want=1", rbusy[1]);
        end
        we = 2'b11;
        wa = {AW'(4), AW'(4)};
        wd = {32'h44, 32'h40};
        #1;
        total++;
        if (rbusy[1] !== 1'b0) begin
            bad++; $display("FAIL clamp_r4_retire got=%b want=0", rbusy[1]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rbusy[1] !== 1'b0) begin
            bad++; $display("FAIL clamp_r4_after got=%b want=0", rbusy[1]);
        end
        total++;
        if (rd[DW +: DW] !== 32'h44) begin
            bad++; $display("FAIL clamp_r4_data got=%h want=00000044", rd[DW +: DW]);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_v = 1'b1;
        iss_a = AW'(2);
        tick();
        tick();
        idle();
        ra = {AW'(5), AW'(2)};
        #1;
        total++;
        if (rbusy[0] !== 1'b1) begin
            bad++; $display("FAIL mid_pre_busy got=%b want=1", rbusy[0]);
        end
        reset = 1'b1;
        iss_v = 1'b1;
        iss_a = AW'(2);
        we    = 2'b01;
        wa    = {AW'(0), AW'(2)};
        wd    = {32'h0, 32'h5555};
        tick();
        reset = 1'b0;
        idle();
        #1;
        total++;
        if (rbusy[0] !== 1'b0) begin
            bad++; $display("FAIL mid_busy got=%b want=0", rbusy[0]);
        end
        total++;
        if (iss_rdy !== 1'b1) begin
            bad++; $display("FAIL mid_iss_rdy got=%b want=1", iss_rdy);
        end
        total++;
        if (rd[0 +: DW] !== '0) begin
            bad++; $display("FAIL mid_r2_data got=%h want=0", rd[0 +: DW]);
        end
        total++;
        if (rd[DW +: DW] !== '0) begin
            bad++; $display("FAIL mid_r5_data got=%h want=0", rd[DW +: DW]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NWR; k++) begin
                we[k]          = ($urandom_range(0, 9) < 4);
                wa[k*AW +: AW] = AW'($urandom_range(0, 7));
                wd[k*DW +: DW] = $urandom;
            end
            for (int j = 0; j < NRD; j++) ra[j*AW +: AW] = AW'($urandom_range(0, 7));
            iss_v = ($urandom_range(0, 9) < 6);
            iss_a = AW'($urandom_range(0, 7));
            #1;
            if (!reset) begin
                model_eval();
                for (int j = 0; j < NRD; j++) begin
                    total++;
                    if (rd[j*DW +: DW] !== exp_rd[j]) begin
                        bad++; $display("FAIL rand_rd%0d cyc=%0d got=%h want=%h", j, c, rd[j*DW +: DW], exp_rd[j]);
                    end
                    total++;
                    if (rbusy[j] !== exp_busy[j]) begin
                        bad++; $display("FAIL rand_rbusy%0d cyc=%0d got=%b want=%b", j, c, rbusy[j], exp_busy[j]);
                    end
                end
                total++;
                if (iss_rdy !== exp_rdy) begin
                    bad++; $display("FAIL rand_iss_rdy cyc=%0d got=%b want=%b", c, iss_rdy, exp_rdy);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ra    = '0;
        iss_a = '0;
        @(negedge clk);
        test_reset();
        test_write_priority();
        test_issue_limit();
        test_issue_then_write();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
